// File: rtl/regfile_port_arbiter.sv
// Write-port arbiter and read bypass for the 16x32 2R1W register file.
// Optional conflict counter is compiled in with `define ARB_STATS_EN.
module regfile_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic [ADDR_W-1:0] rf_rd_addr1_o,
  output logic [ADDR_W-1:0] rf_rd_addr2_o,
  input  logic [DATA_W-1:0] rf_rd_data1_i,
  input  logic [DATA_W-1:0] rf_rd_data2_i,
  output logic              rf_wr_en_o,
  output logic [ADDR_W-1:0] rf_wr_addr_o,
  output logic [DATA_W-1:0] rf_wr_data_o,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
`ifdef ARB_STATS_EN
  input  logic              stats_clr_i,
  output logic [15:0]       conflict_cnt_o,
`endif
  output logic              hazard1_o,
  output logic              hazard2_o
);

  // last_grant: 1'b1 means B was granted last, so A wins the next conflict
  logic              last_grant_q, last_grant_d;
  logic              byp1_q, byp1_d;
  logic              byp2_q, byp2_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;
  logic              grant_a_s, grant_b_s;

  // Round-robin grant; reset drops any grant immediately
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (!reset_n_i) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else if (a_valid_i && b_valid_i) begin
      if (last_grant_q) begin
        grant_a_s = 1'b1;
      end else begin
        grant_b_s = 1'b1;
      end
    end else if (a_valid_i) begin
      grant_a_s = 1'b1;
    end else if (b_valid_i) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Write-port mux and handshake outputs
  always_comb begin
    a_ready_o    = grant_a_s;
    b_ready_o    = grant_b_s;
    rf_wr_en_o   = grant_a_s | grant_b_s;
    rf_wr_addr_o = {ADDR_W{1'b0}};
    rf_wr_data_o = {DATA_W{1'b0}};
    if (grant_a_s) begin
      rf_wr_addr_o = a_addr_i;
      rf_wr_data_o = a_data_i;
    end else if (grant_b_s) begin
      rf_wr_addr_o = b_addr_i;
      rf_wr_data_o = b_data_i;
    end else begin
      rf_wr_addr_o = {ADDR_W{1'b0}};
      rf_wr_data_o = {DATA_W{1'b0}};
    end
  end

  // Hazards come only from a writer that is requesting but not granted
  always_comb begin
    hazard1_o = 1'b0;
    hazard2_o = 1'b0;
    if (reset_n_i) begin
      hazard1_o = (a_valid_i && !grant_a_s && (a_addr_i == rd_addr1_i)) ||
                  (b_valid_i && !grant_b_s && (b_addr_i == rd_addr1_i));
      hazard2_o = (a_valid_i && !grant_a_s && (a_addr_i == rd_addr2_i)) ||
                  (b_valid_i && !grant_b_s && (b_addr_i == rd_addr2_i));
    end else begin
      hazard1_o = 1'b0;
      hazard2_o = 1'b0;
    end
  end

  // Next-state for arbitration history and read bypass capture
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_a_s) begin
      last_grant_d = 1'b0;
    end else if (grant_b_s) begin
      last_grant_d = 1'b1;
    end else begin
      last_grant_d = last_grant_q;
    end
    byp1_d     = rf_wr_en_o && (rf_wr_addr_o == rd_addr1_i);
    byp2_d     = rf_wr_en_o && (rf_wr_addr_o == rd_addr2_i);
    byp_data_d = rf_wr_data_o;
  end

  // State registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_grant_q <= 1'b1;
      byp1_q       <= 1'b0;
      byp2_q       <= 1'b0;
      byp_data_q   <= {DATA_W{1'b0}};
    end else begin
      last_grant_q <= last_grant_d;
      byp1_q       <= byp1_d;
      byp2_q       <= byp2_d;
      byp_data_q   <= byp_data_d;
    end
  end

  // The regfile returns pre-write data, so a same-cycle write overrides it
  assign rf_rd_addr1_o = rd_addr1_i;
  assign rf_rd_addr2_o = rd_addr2_i;
  assign rd_data1_o    = byp1_q ? byp_data_q : rf_rd_data1_i;
  assign rd_data2_o    = byp2_q ? byp_data_q : rf_rd_data2_i;

`ifdef ARB_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating conflict counter; clear takes priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (stats_clr_i) begin
      cnt_d = 16'h0000;
    end else if (a_valid_i && b_valid_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed self-checking bench for regfile_port_arbiter with a small regfile model.
module tb_regfile_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [3:0]  a_addr, b_addr, rd_addr1, rd_addr2, rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
  logic [31:0] a_data, b_data, rf_rd_data1, rf_rd_data2, rf_wr_data, rd_data1, rd_data2;
  logic        rf_wr_en, hazard1, hazard2;
`ifdef ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] conflict_cnt;
`endif

  // Regfile model: registered, pre-write reads; optional override of read data
  logic [31:0] mem [16] = '{default: 32'h0};
  logic [31:0] mdl1 = 32'h0, mdl2 = 32'h0;
  logic        rf_ovr;
  logic [31:0] ovr1, ovr2;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
    mdl1 <= mem[rf_rd_addr1];
    mdl2 <= mem[rf_rd_addr2];
  end

  assign rf_rd_data1 = rf_ovr ? ovr1 : mdl1;
  assign rf_rd_data2 = rf_ovr ? ovr2 : mdl2;

  regfile_port_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_addr_i(a_addr), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_addr_i(b_addr), .b_data_i(b_data),
    .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
    .rf_rd_addr1_o(rf_rd_addr1), .rf_rd_addr2_o(rf_rd_addr2),
    .rf_rd_data1_i(rf_rd_data1), .rf_rd_data2_i(rf_rd_data2),
    .rf_wr_en_o(rf_wr_en), .rf_wr_addr_o(rf_wr_addr), .rf_wr_data_o(rf_wr_data),
    .rd_data1_o(rd_data1), .rd_data2_o(rd_data2),
`ifdef ARB_STATS_EN
    .stats_clr_i(stats_clr), .conflict_cnt_o(conflict_cnt),
`endif
    .hazard1_o(hazard1), .hazard2_o(hazard2)
  );

  task automatic test_reset;
    #1;
    n_checks++;
    if ({a_ready, b_ready, rf_wr_en, hazard1, hazard2} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {a_ready, b_ready, rf_wr_en, hazard1, hazard2});
    end
    n_checks++;
    if ({rd_data1, rd_data2} !== {32'hCAFE0001, 32'hCAFE0002}) begin
      n_fail++;
      $display("FAIL reset_rddata: got %h %h expected cafe0001 cafe0002", rd_data1, rd_data2);
    end
    n_checks++;
    if ({rf_rd_addr1, rf_rd_addr2} !== 8'h12) begin
      n_fail++;
      $display("FAIL rd_addr_pass: got %h expected 12", {rf_rd_addr1, rf_rd_addr2});
    end
`ifdef ARB_STATS_EN
    n_checks++;
    if (conflict_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d expected 0", conflict_cnt);
    end
`endif
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_single_write;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 4'd3; a_data = 32'hDEADBEEF; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    #1;
    n_checks++;
    if ({a_ready, b_ready, rf_wr_en, rf_wr_addr, rf_wr_data} !== {3'b101, 4'd3, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL a_only: got %b %h %h expected 101 3 deadbeef", {a_ready, b_ready, rf_wr_en}, rf_wr_addr, rf_wr_data);
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b1; b_addr = 4'd4; b_data = 32'h00000044;
    #1;
    n_checks++;
    if ({a_ready, b_ready, rf_wr_en, rf_wr_addr, rf_wr_data} !== {3'b011, 4'd4, 32'h44}) begin
      n_fail++;
      $display("FAIL b_only: got %b %h %h expected 011 4 00000044", {a_ready, b_ready, rf_wr_en}, rf_wr_addr, rf_wr_data);
    end
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    n_checks++;
    if ({a_ready, b_ready, rf_wr_en, rf_wr_addr, rf_wr_data} !== {3'b000, 4'd0, 32'h0}) begin
      n_fail++;
      $display("FAIL idle_port: got %b %h %h expected 000 0 0", {a_ready, b_ready, rf_wr_en}, rf_wr_addr, rf_wr_data);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] pat_a;
    pat_a = 3'b101;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 4'd1; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 32'h22;
    rd_addr1 = 4'd2; rd_addr2 = 4'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({a_ready, b_ready, hazard1, hazard2} !== {pat_a[i], !pat_a[i], pat_a[i], !pat_a[i]}) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got rdy/haz %b expected %b", i, {a_ready, b_ready, hazard1, hazard2},
                 {pat_a[i], !pat_a[i], pat_a[i], !pat_a[i]});
      end
      n_checks++;
      if (rf_wr_data !== (pat_a[i] ? 32'h11 : 32'h22)) begin
        n_fail++;
        $display("FAIL rr_data%0d: got %h", i, rf_wr_data);
      end
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
`ifdef ARB_STATS_EN
    n_checks++;
    if (conflict_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL rr_cnt: got %0d expected 3", conflict_cnt);
    end
`endif
  endtask

  task automatic test_bypass;
    @(negedge clk);
    rf_ovr = 1'b1; ovr1 = 32'h0; ovr2 = 32'hBBBB0006;
    a_valid = 1'b1; a_addr = 4'd5; a_data = 32'h12345678; rd_addr1 = 4'd5; rd_addr2 = 4'd6;
    @(posedge clk); #1;
    n_checks++;
    if ({rd_data1, rd_data2} !== {32'h12345678, 32'hBBBB0006}) begin
      n_fail++;
      $display("FAIL bypass_hit: got %h %h expected 12345678 bbbb0006", rd_data1, rd_data2);
    end
    @(negedge clk);
    a_valid = 1'b0; ovr1 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    n_checks++;
    if (rd_data1 !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL bypass_clear: got %h expected a5a5a5a5", rd_data1);
    end
  endtask

  task automatic test_dual_bypass;
    @(negedge clk);
    ovr1 = 32'h0; ovr2 = 32'h0;
    a_valid = 1'b1; a_addr = 4'd7; a_data = 32'h77770000; rd_addr1 = 4'd7; rd_addr2 = 4'd7;
    @(posedge clk); #1;
    n_checks++;
    if ({rd_data1, rd_data2} !== {32'h77770000, 32'h77770000}) begin
      n_fail++;
      $display("FAIL dual_bypass: got %h %h expected 77770000 77770000", rd_data1, rd_data2);
    end
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic test_collision;
    @(negedge clk);
    rf_ovr = 1'b0; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    b_valid = 1'b1; b_addr = 4'd10; b_data = 32'hB0;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 4'd9; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 4'd9; b_data = 32'h2;
    rd_addr1 = 4'd9; rd_addr2 = 4'd9;
    #1;
    n_checks++;
    if ({a_ready, b_ready, hazard1, hazard2} !== 4'b1011) begin
      n_fail++;
      $display("FAIL coll_first: got %b expected 1011", {a_ready, b_ready, hazard1, hazard2});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rd_data1, rd_data2} !== {32'h1, 32'h1}) begin
      n_fail++;
      $display("FAIL coll_byp_a: got %h %h expected 1 1", rd_data1, rd_data2);
    end
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    n_checks++;
    if ({a_ready, b_ready, hazard1, rf_wr_data} !== {3'b010, 32'h2}) begin
      n_fail++;
      $display("FAIL coll_second: got %b %h expected 010 2", {a_ready, b_ready, hazard1}, rf_wr_data);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rd_data1 !== 32'h2) begin
      n_fail++;
      $display("FAIL coll_byp_b: got %h expected 2", rd_data1);
    end
    @(negedge clk);
    b_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({rd_data1, mem[9]} !== {32'h2, 32'h2}) begin
      n_fail++;
      $display("FAIL coll_final: got rd %h mem %h expected 2 2", rd_data1, mem[9]);
    end
`ifdef ARB_STATS_EN
    n_checks++;
    if (conflict_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL coll_cnt: got %0d expected 4", conflict_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    a_valid = 1'b1; a_addr = 4'd12; a_data = 32'hA12;
    b_valid = 1'b1; b_addr = 4'd13; b_data = 32'hB13;
    #1;
    n_checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_pre_a: got %b expected 10", {a_ready, b_ready});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_pre_b: got %b expected 01", {a_ready, b_ready});
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({a_ready, b_ready, rf_wr_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_in_reset: got %b expected 000", {a_ready, b_ready, rf_wr_en});
    end
`ifdef ARB_STATS_EN
    n_checks++;
    if (conflict_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_cnt: got %0d expected 0", conflict_cnt);
    end
`endif
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({a_ready, b_ready, rf_wr_addr} !== {2'b10, 4'd12}) begin
      n_fail++;
      $display("FAIL mid_post: got %b %h expected 10 c", {a_ready, b_ready}, rf_wr_addr);
    end
`ifdef ARB_STATS_EN
    @(negedge clk);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (conflict_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_priority: got %0d expected 0", conflict_cnt);
    end
    stats_clr = 1'b0;
`endif
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; rf_ovr = 1'b1; ovr1 = 32'hCAFE0001; ovr2 = 32'hCAFE0002;
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 4'd1; b_addr = 4'd1;
    a_data = 32'h0; b_data = 32'h0; rd_addr1 = 4'd1; rd_addr2 = 4'd2;
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    test_single_write();
    test_round_robin();
    test_bypass();
    test_dual_bypass();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
